// File: rtl/veggie_pkg.sv
// Shared types and screen geometry for the veggie game engine.
package veggie_pkg;

  localparam int SCREEN_W     = 1024;
  localparam int SCREEN_H     = 768;
  localparam int VEG_W        = 128;
  localparam int VEG_H        = 128;
  localparam int GRAVITY      = 1;
  localparam int LAUNCH_VY    = 24;
  localparam int SPAWN_FRAMES = 45;
  localparam int X_MAX        = SCREEN_W - VEG_W;
  localparam int Y_START      = SCREEN_H - VEG_H;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLYING = 2'd1,
    SPLIT  = 2'd2
  } slot_state_t;

  typedef enum logic {
    SWEEP_IDLE = 1'b0,
    SWEEP_RUN  = 1'b1
  } sweep_state_t;

  // Velocities are two's complement; positions are unsigned screen pixels.
  typedef struct packed {
    slot_state_t state;
    logic [10:0] x;
    logic [9:0]  y;
    logic [7:0]  vx;
    logic [7:0]  vy;
  } veggie_t;

endpackage

// File: rtl/veggie_slot_update.sv
// Combinational per-slot step: launch, motion with wall bounce, exit and katana hit.
module veggie_slot_update
  import veggie_pkg::*;
(
  input  veggie_t     cur,
  input  logic        spawn_en,
  input  logic [12:0] random_in,
  input  logic [10:0] katana_x,
  input  logic [9:0]  katana_y,
  output veggie_t     nxt,
  output logic        hit,
  output logic        miss,
  output logic        launched
);

  logic [11:0] x0, y0, kx, ky, x_sum, y_sum;
  logic [9:0]  rx;
  logic        in_box, moving_down, exiting;

  assign x0    = {1'b0, cur.x};
  assign y0    = {2'b0, cur.y};
  assign kx    = {1'b0, katana_x};
  assign ky    = {2'b0, katana_y};
  assign x_sum = x0 + {{4{cur.vx[7]}}, cur.vx};
  assign y_sum = y0 + {{4{cur.vy[7]}}, cur.vy};
  assign rx    = (random_in[9:0] > 10'(X_MAX)) ? random_in[9:0] - 10'(X_MAX) : random_in[9:0];

  // Hit box is tested on the position before this frame's move.
  assign in_box = (kx >= x0) && (kx < x0 + 12'(VEG_W)) &&
                  (ky >= y0) && (ky < y0 + 12'(VEG_H));
  assign moving_down = !cur.vy[7] && (cur.vy != 8'd0);
  assign exiting     = moving_down && !y_sum[11] && (y_sum >= 12'(Y_START));

  always_comb begin
    nxt      = cur;
    hit      = 1'b0;
    miss     = 1'b0;
    launched = 1'b0;
    if (cur.state == IDLE) begin
      if (spawn_en) begin
        nxt.state = FLYING;
        nxt.x     = {1'b0, rx};
        nxt.y     = 10'(Y_START);
        nxt.vx    = {5'b0, random_in[12:10]} - 8'd3;
        nxt.vy    = 8'(-LAUNCH_VY);
        launched  = 1'b1;
      end
    end else begin
      if (x_sum[11]) begin
        nxt.x  = 11'd0;
        nxt.vx = -cur.vx;
      end else if (x_sum > 12'(X_MAX)) begin
        nxt.x  = 11'(X_MAX);
        nxt.vx = -cur.vx;
      end else begin
        nxt.x = x_sum[10:0];
      end
      if (y_sum[11])                    nxt.y = 10'd0;
      else if (y_sum > 12'(Y_START))    nxt.y = 10'(Y_START);
      else                              nxt.y = y_sum[9:0];
      nxt.vy = cur.vy + 8'(GRAVITY);
      // Exit takes priority over a same-step hit: no score and no miss then.
      if (exiting) begin
        nxt.state = IDLE;
        miss      = (cur.state == FLYING) && !in_box;
      end else if (cur.state == FLYING && in_box) begin
        nxt.state = SPLIT;
        hit       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/veggie_manager.sv
// Frame-rate veggie engine: one slot updated per clock in a sweep after each frame.
module veggie_manager
  import veggie_pkg::*;
#(
  parameter int N_VEG   = 4,
  parameter int SCORE_W = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 frame_done_in,
  input  logic [10:0]          katana_x,
  input  logic [9:0]           katana_y,
  input  logic [15:0]          random_in,
  output logic [N_VEG*11-1:0]  veg_x_out,
  output logic [N_VEG*10-1:0]  veg_y_out,
  output logic [N_VEG-1:0]     veg_active_out,
  output logic [N_VEG-1:0]     veg_split_out,
  output logic                 split_pulse_out,
  output logic [SCORE_W-1:0]   score_out,
  output logic [SCORE_W-1:0]   miss_out,
  output logic                 busy_out,
  output sweep_state_t         sweep_state
);

  localparam int IDX_W = (N_VEG > 1) ? $clog2(N_VEG) : 1;
  localparam int CNT_W = $clog2(SPAWN_FRAMES);

  veggie_t            slots [N_VEG];
  veggie_t            cur, nxt;
  sweep_state_t       state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   spawn_cnt;
  logic               spawn_pending, last, hit, miss, launched, start;
  logic               unused_random;

  assign unused_random = ^random_in[15:13];
  assign cur   = slots[idx];
  assign last  = (idx == IDX_W'(N_VEG - 1));
  assign start = (sweep_state == SWEEP_IDLE) && frame_done_in;

  veggie_slot_update u_update (
    .cur       (cur),
    .spawn_en  (spawn_pending),
    .random_in (random_in[12:0]),
    .katana_x  (katana_x),
    .katana_y  (katana_y),
    .nxt       (nxt),
    .hit       (hit),
    .miss      (miss),
    .launched  (launched)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) sweep_state <= SWEEP_IDLE;
    else        sweep_state <= state_nxt;
  end

  always_comb begin
    state_nxt = sweep_state;
    case (sweep_state)
      SWEEP_IDLE: if (frame_done_in) state_nxt = SWEEP_RUN;
      SWEEP_RUN:  if (last)          state_nxt = SWEEP_IDLE;
      default:                       state_nxt = SWEEP_IDLE;
    endcase
  end

  always_comb begin
    busy_out = (sweep_state == SWEEP_RUN);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < N_VEG; i++) slots[i] <= '0;
      idx             <= '0;
      spawn_cnt       <= '0;
      spawn_pending   <= 1'b0;
      split_pulse_out <= 1'b0;
      score_out       <= '0;
      miss_out        <= '0;
    end else begin
      split_pulse_out <= 1'b0;
      if (start) begin
        idx <= '0;
        if (spawn_cnt == CNT_W'(SPAWN_FRAMES - 1)) spawn_pending <= 1'b1;
        else                                       spawn_cnt     <= spawn_cnt + 1'b1;
      end else if (busy_out) begin
        slots[idx] <= nxt;
        idx        <= last ? '0 : idx + 1'b1;
        // An unserved spawn leaves the counter at its terminal value so the next frame retries.
        if (launched) begin
          spawn_pending <= 1'b0;
          spawn_cnt     <= '0;
        end else if (last) begin
          spawn_pending <= 1'b0;
        end
        if (hit) begin
          split_pulse_out <= 1'b1;
          if (score_out != '1) score_out <= score_out + 1'b1;
        end
        if (miss && miss_out != '1) miss_out <= miss_out + 1'b1;
      end
    end
  end

  always_comb begin
    veg_x_out      = '0;
    veg_y_out      = '0;
    veg_active_out = '0;
    veg_split_out  = '0;
    for (int i = 0; i < N_VEG; i++) begin
      veg_x_out[i*11 +: 11] = slots[i].x;
      veg_y_out[i*10 +: 10] = slots[i].y;
      veg_active_out[i]     = (slots[i].state != IDLE);
      veg_split_out[i]      = (slots[i].state == SPLIT);
    end
  end

endmodule

// File: tb/tb_veggie_manager.sv
// Scoreboard bench: a 4-slot engine plus a 1-slot engine sharing the same stimulus.
module tb_veggie_manager;
  import veggie_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fd  = 1'b0;
  logic [10:0] kx  = 11'd2047;
  logic [9:0]  ky  = 10'd1023;
  logic [15:0] rnd = 16'h0100;

  logic [43:0] x4;
  logic [39:0] y4;
  logic [3:0]  act4, spl4;
  logic        pulse4, busy4;
  logic [15:0] score4, miss4;
  sweep_state_t sst4;

  logic [10:0] x1;
  logic [9:0]  y1;
  logic        act1, spl1, pulse1, busy1;
  logic [15:0] score1, miss1;
  sweep_state_t sst1;

  veggie_manager #(.N_VEG(4), .SCORE_W(16)) dut (
    .clk_in(clk), .rst_in(rst), .frame_done_in(fd), .katana_x(kx), .katana_y(ky),
    .random_in(rnd), .veg_x_out(x4), .veg_y_out(y4), .veg_active_out(act4),
    .veg_split_out(spl4), .split_pulse_out(pulse4), .score_out(score4),
    .miss_out(miss4), .busy_out(busy4), .sweep_state(sst4)
  );

  veggie_manager #(.N_VEG(1), .SCORE_W(16)) dut1 (
    .clk_in(clk), .rst_in(rst), .frame_done_in(fd), .katana_x(kx), .katana_y(ky),
    .random_in(rnd), .veg_x_out(x1), .veg_y_out(y1), .veg_active_out(act1),
    .veg_split_out(spl1), .split_pulse_out(pulse1), .score_out(score1),
    .miss_out(miss1), .busy_out(busy1), .sweep_state(sst1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       frame;
    int       which;
    int       slot;
    int       ex;
    int       ey;
    logic [3:0] act;
    logic [3:0] spl;
    int       sc;
    int       ms;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   frame_no = 0, len4 = 0, len1 = 0, pulses4 = 0, pulses1 = 0;
  logic prev_busy4 = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic void push(input int w, input int f, input int s, input int x, input int y,
                               input logic [3:0] a, input logic [3:0] sp, input int sc, input int ms);
    exp_t e;
    e.frame = f; e.which = w; e.slot = s; e.ex = x; e.ey = y;
    e.act = a; e.spl = sp; e.sc = sc; e.ms = ms;
    exp_q.push_back(e);
  endfunction

  task automatic compare_exp(input exp_t e);
    logic [3:0] act, spl;
    int sc, ms, x, y;
    string tag;
    x = 0; y = 0;
    if (e.which == 0) begin
      act = act4; spl = spl4; sc = score4; ms = miss4;
      if (e.slot >= 0) begin
        x = int'(x4[e.slot*11 +: 11]);
        y = int'(y4[e.slot*10 +: 10]);
      end
    end else begin
      act = {3'b000, act1}; spl = {3'b000, spl1}; sc = score1; ms = miss1;
      x = int'(x1); y = int'(y1);
    end
    tag = $sformatf("f%0d_dut%0d", e.frame, e.which);
    check({tag, "_active"}, int'(act), int'(e.act));
    check({tag, "_split"},  int'(spl), int'(e.spl));
    check({tag, "_score"},  sc, e.sc);
    check({tag, "_miss"},   ms, e.ms);
    if (e.slot >= 0) begin
      check({tag, "_x"}, x, e.ex);
      check({tag, "_y"}, y, e.ey);
    end
  endtask

  // Monitor: a falling busy on the 4-slot engine marks a completed sweep.
  always @(negedge clk) begin
    if (rst) begin
      len4 = 0; len1 = 0; prev_busy4 = 1'b0;
    end else begin
      if (pulse4) pulses4++;
      if (pulse1) pulses1++;
      if (busy4) len4++;
      if (busy1) len1++;
      if (prev_busy4 && !busy4) begin
        frame_no++;
        check($sformatf("f%0d_busy_len4", frame_no), len4, 4);
        check($sformatf("f%0d_busy_len1", frame_no), len1, 1);
        len4 = 0; len1 = 0;
        while (exp_q.size() > 0 && exp_q[0].frame <= frame_no) compare_exp(exp_q.pop_front());
      end
      prev_busy4 = busy4;
    end
  end

  task automatic frame(input int f, input bit twice);
    rnd = (f == 90) ? 16'h1F7E : (f == 95) ? 16'h0000 : 16'h0100;
    if (f >= 96 && f <= 99) begin kx = 11'd890;  ky = 10'd540;  end
    else                    begin kx = 11'd2047; ky = 10'd1023; end
    @(posedge clk); #1 fd = 1'b1;
    @(posedge clk); #1 if (!twice) fd = 1'b0;
    @(posedge clk); #1 fd = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_active4", int'(act4), 0);
    check("rst_score4",  int'(score4), 0);
    check("rst_miss4",   int'(miss4), 0);
    check("rst_busy4",   int'(busy4), 0);
    check("rst_xy4",     int'(x4 != 0 || y4 != 0), 0);
    check("rst_state4",  int'(sst4), int'(SWEEP_IDLE));
    check("rst_active1", int'(act1), 0);
    rst = 1'b0;

    push(0, 44, -1,   0,   0, 4'b0000, 4'b0000, 0, 0);
    push(0, 45,  0, 256, 640, 4'b0001, 4'b0000, 0, 0);
    push(1, 45,  0, 256, 640, 4'b0001, 4'b0000, 0, 0);
    push(0, 46,  0, 253, 616, 4'b0001, 4'b0000, 0, 0);
    push(0, 50,  0, 241, 530, 4'b0001, 4'b0000, 0, 0);
    push(0, 51,  0, 238, 511, 4'b0001, 4'b0000, 0, 0);
    push(0, 89,  0, 124, 530, 4'b0001, 4'b0000, 0, 0);
    push(0, 90,  1, 894, 640, 4'b0011, 4'b0000, 0, 0);
    push(1, 90,  0, 121, 550, 4'b0001, 4'b0000, 0, 0);
    push(0, 91,  1, 896, 616, 4'b0011, 4'b0000, 0, 0);
    push(0, 92,  1, 892, 593, 4'b0011, 4'b0000, 0, 0);
    push(0, 93,  0, 112, 616, 4'b0011, 4'b0000, 0, 0);
    push(0, 94, -1,   0,   0, 4'b0010, 4'b0000, 0, 1);
    push(1, 94, -1,   0,   0, 4'b0000, 4'b0000, 0, 1);
    push(0, 95,  1, 880, 530, 4'b0010, 4'b0000, 0, 1);
    push(1, 95,  0,   0, 640, 4'b0001, 4'b0000, 0, 1);
    push(0, 96,  1, 876, 511, 4'b0010, 4'b0010, 1, 1);
    push(1, 96,  0,   0, 616, 4'b0001, 4'b0000, 0, 1);
    push(0, 97,  1, 872, 493, 4'b0010, 4'b0010, 1, 1);
    push(1, 97,  0,   3, 593, 4'b0001, 4'b0000, 0, 1);
    push(0, 100, -1,  0,   0, 4'b0010, 4'b0010, 1, 1);
    push(0, 134, 1, 724, 530, 4'b0010, 4'b0010, 1, 1);
    push(0, 135, 0, 256, 640, 4'b0011, 4'b0010, 1, 1);
    push(0, 138, 1, 708, 616, 4'b0011, 4'b0010, 1, 1);
    push(0, 139, -1,  0,   0, 4'b0001, 4'b0000, 1, 1);
    push(1, 139, 0, 129, 530, 4'b0001, 4'b0000, 0, 1);

    for (int f = 1; f <= 139; f++) frame(f, f == 50);

    // Abort a sweep with reset once it is under way.
    @(posedge clk); #1 fd = 1'b1;
    @(posedge clk); #1 fd = 1'b0;
    check("busy_before_rst", int'(busy4), 1);
    rst = 1'b1;
    #1;
    check("rstmid_active4", int'(act4), 0);
    check("rstmid_split4",  int'(spl4), 0);
    check("rstmid_score4",  int'(score4), 0);
    check("rstmid_miss4",   int'(miss4), 0);
    check("rstmid_busy4",   int'(busy4), 0);
    check("rstmid_xy4",     int'(x4 != 0 || y4 != 0), 0);
    check("rstmid_pulse4",  int'(pulse4), 0);
    check("rstmid_score1",  int'(score1), 0);
    check("rstmid_miss1",   int'(miss1), 0);
    check("rstmid_active1", int'(act1), 0);
    @(posedge clk); #1 rst = 1'b0;

    push(0, 140, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    push(1, 140, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    frame(140, 1'b0);
    repeat (4) @(posedge clk);

    check("split_pulses4", pulses4, 1);
    check("split_pulses1", pulses1, 0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
